// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 serial receiver, LSB first, mid-bit sampling.
// Ports:
//   clk        - single clock, all logic on posedge
//   rst        - synchronous active-low reset
//   rx_serial  - asynchronous serial line, idle high
//   rx_data    - received byte, valid while rx_valid is high, held otherwise
//   rx_valid   - one-cycle pulse per good frame
//   frame_err  - one-cycle pulse when the stop bit samples low
//   busy       - high whenever the receiver is not idle
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t                 state;
    logic [15:0]            clk_cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    // Synchroniser chain; resets to the idle (high) line level so a
    // reset never looks like a start edge by itself.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        rx_valid  <= 1'b0;
        frame_err <= 1'b0;
        if (!rst) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            rx_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                // Re-check the start bit half a bit in; a high line
                // there means the falling edge was a glitch.
                START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_M1) begin
                        clk_cnt         <= '0;
                        shift[bit_idx]  <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (clk_cnt == BIT_M1) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                // Line held low after a bad stop bit: wait for it to
                // return high so the break is not taken as a new start.
                BRK: begin
                    clk_cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    clk_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: scoreboard bench for uart_rx_frontend.
// Frames are predicted from the 8N1 rules and checked by a monitor.
module tb_uart_rx_frontend;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_serial = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    uart_rx_frontend #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_serial(rx_serial),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   cyc    = 0;
    int   last_v = -1000;
    logic prev_pulse = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    // Monitor: every output pulse is matched against the next prediction.
    always @(negedge clk) begin
        exp_t e;
        logic pulse;
        cyc++;
        pulse = rx_valid | frame_err;
        if (rx_valid && frame_err) chk("valid_err_overlap", 1, 0);
        if (pulse && prev_pulse) chk("pulse_width", 2, 1);
        if (pulse) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b data=%h, expected no pulse",
                         rx_valid, frame_err, rx_data);
            end else begin
                e = sb.pop_front();
                chk("pulse_is_err", int'(frame_err), int'(e.err));
                if (!e.err) chk("rx_data", int'(rx_data), int'(e.data));
                if (e.gap >= 0 && rx_valid) chk("pulse_spacing", cyc - last_v, e.gap);
            end
            if (rx_valid) last_v = cyc;
        end
        prev_pulse = pulse;
    end

    task automatic drive(input logic v, input int n);
        rx_serial = v;
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame; a low stop bit is followed by a break of post_low
    // extra cycles and then one bit time of idle line.
    task automatic frame(input logic [7:0] d, input logic stop,
                         input int post_low, input int gap);
        exp_t e;
        e.err  = ~stop;
        e.data = stop ? d : 8'h00;
        e.gap  = gap;
        sb.push_back(e);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(d[i], CPB);
        drive(stop, CPB);
        if (!stop) begin
            drive(1'b0, post_low);
            drive(1'b1, CPB);
        end
    endtask

    initial begin
        int t;
        int r;
        logic [7:0] d96;

        // Reset with line low
        rst = 1'b0;
        rx_serial = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_rx_valid", int'(rx_valid), 0);
            chk("reset_frame_err", int'(frame_err), 0);
            chk("reset_busy", int'(busy), 0);
            chk("reset_rx_data", int'(rx_data), 0);
        end
        rx_serial = 1'b1;
        rst = 1'b1;
        drive(1'b1, 20);
        chk("idle_busy", int'(busy), 0);

        // Single frame
        frame(8'hA5, 1'b1, 0, -1);
        drive(1'b1, 20);

        // Back-to-back frames, zero idle
        frame(8'h00, 1'b1, 0, -1);
        frame(8'hFF, 1'b1, 0, 10 * CPB);
        frame(8'h3C, 1'b1, 0, 10 * CPB);
        drive(1'b1, 20);

        // Start-bit glitch
        drive(1'b0, 5);
        chk("glitch_busy_high", int'(busy), 1);
        drive(1'b1, 20);
        chk("glitch_busy_low", int'(busy), 0);

        // Bad stop bit, held break, then a good frame
        frame(8'h55, 1'b0, 40, -1);
        chk("break_released_busy", int'(busy), 0);
        frame(8'h81, 1'b1, 0, -1);
        drive(1'b1, 20);

        // Reset during bit 4 of 0x96
        d96 = 8'h96;
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(d96[i], CPB);
        rx_serial = d96[4];
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_rx_valid", int'(rx_valid), 0);
        rx_serial = 1'b1;
        rst = 1'b1;
        drive(1'b1, 20);
        frame(8'h42, 1'b1, 0, -1);
        drive(1'b1, 20);

        // Randomised traffic: good frames, bad stops, glitches
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                drive(1'b0, $urandom_range(1, 6));
                drive(1'b1, CPB);
            end else begin
                frame(8'($urandom), (r != 1), $urandom_range(0, 30), -1);
                drive(1'b1, $urandom_range(0, 20));
            end
        end
        drive(1'b1, 20);

        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        chk("final_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
